// File: rtl/sop_lut_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : sop_lut_sweeper
//  Description : Programmable N-input boolean function held as a 2^N-bit
//                truth table. Provides registered direct evaluation of an
//                input vector and a sweep engine that streams f(k) for every
//                input combination k and reports the number of minterms.
//  Revision    : 1.0 - initial release
// ============================================================================
module sop_lut_sweeper #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [(1<<N)-1:0]   tt_in,
    input  logic [N-1:0]        in_vec,
    output logic                s,
    input  logic                start,
    output logic                busy,
    output logic                sweep_valid,
    output logic [N-1:0]        sweep_idx,
    output logic                sweep_s,
    output logic                done,
    output logic [N:0]          minterm_count
);

    localparam int             c_TT_W     = 1 << N;
    localparam logic [N-1:0]   c_IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]   c_IDX_LAST = {N{1'b1}};

    localparam logic [1:0]     c_IDLE  = 2'd0;
    localparam logic [1:0]     c_SWEEP = 2'd1;
    localparam logic [1:0]     c_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [c_TT_W-1:0] r_table;
    logic              r_s;
    logic [N-1:0]      r_idx;
    logic              r_sweep_s;
    logic [N:0]        r_acc;
    logic [N:0]        r_minterm_count;

    logic              w_load_ok;
    logic              w_start_ok;
    logic [c_TT_W-1:0] w_table_eff;
    logic [N-1:0]      w_idx_next;
    logic [N:0]        w_acc_next;
    logic              w_last;

    // Decode accepted commands and next-step datapath values.
    always_comb begin
        w_load_ok   = (r_state == c_IDLE) && load;
        w_start_ok  = (r_state == c_IDLE) && start;
        // A sweep started together with a load must see the new table.
        w_table_eff = w_load_ok ? tt_in : r_table;
        w_idx_next  = r_idx + c_IDX_ONE;
        w_acc_next  = r_acc + {{N{1'b0}}, r_sweep_s};
        w_last      = (r_idx == c_IDX_LAST);
    end

    // Truth table storage; writable only while idle so a sweep sees a frozen table.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_table <= '0;
        end else if (w_load_ok) begin
            r_table <= tt_in;
        end
    end

    // Direct evaluation, one-cycle latency, uses the table as it was before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= 1'b0;
        end else begin
            r_s <= r_table[in_vec];
        end
    end

    // Sweep controller: IDLE -> SWEEP (2^N cycles) -> DONE (1 cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_start_ok) r_state <= c_SWEEP;
                c_SWEEP: if (w_last)     r_state <= c_DONE;
                c_DONE:                  r_state <= c_IDLE;
                default:                 r_state <= c_IDLE;
            endcase
        end
    end

    // Sweep datapath: index, streamed result and minterm accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx           <= '0;
            r_sweep_s       <= 1'b0;
            r_acc           <= '0;
            r_minterm_count <= '0;
        end else begin
            if (w_start_ok) begin
                r_idx     <= '0;
                r_acc     <= '0;
                r_sweep_s <= w_table_eff[0];
            end else if (r_state == c_SWEEP) begin
                r_acc <= w_acc_next;
                if (w_last) begin
                    // Index parks on all-ones; it never wraps inside a sweep.
                    r_minterm_count <= w_acc_next;
                end else begin
                    r_idx     <= w_idx_next;
                    r_sweep_s <= r_table[w_idx_next];
                end
            end
        end
    end

    assign s             = r_s;
    assign busy          = (r_state == c_SWEEP);
    assign sweep_valid   = (r_state == c_SWEEP);
    assign sweep_idx     = r_idx;
    assign sweep_s       = r_sweep_s;
    assign done          = (r_state == c_DONE);
    assign minterm_count = r_minterm_count;

endmodule
`default_nettype wire

// File: tb/tb_sop_lut_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sop_lut_sweeper
//  Description : Self-checking bench for sop_lut_sweeper (N=4 and N=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_lut_sweeper;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // N = 4 instance
    logic        rst, load, start;
    logic [15:0] tt_in;
    logic [3:0]  in_vec;
    logic        s, busy, sweep_valid, sweep_s, done;
    logic [3:0]  sweep_idx;
    logic [4:0]  minterm_count;

    // N = 2 instance
    logic        rst_2, load_2, start_2;
    logic [3:0]  tt_in_2;
    logic [1:0]  in_vec_2;
    logic        s_2, busy_2, sweep_valid_2, sweep_s_2, done_2;
    logic [1:0]  sweep_idx_2;
    logic [2:0]  minterm_count_2;

    sop_lut_sweeper #(.N(4)) u_dut (
        .clk(clk), .rst(rst), .load(load), .tt_in(tt_in), .in_vec(in_vec),
        .s(s), .start(start), .busy(busy), .sweep_valid(sweep_valid),
        .sweep_idx(sweep_idx), .sweep_s(sweep_s), .done(done),
        .minterm_count(minterm_count)
    );

    sop_lut_sweeper #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst_2), .load(load_2), .tt_in(tt_in_2), .in_vec(in_vec_2),
        .s(s_2), .start(start_2), .busy(busy_2), .sweep_valid(sweep_valid_2),
        .sweep_idx(sweep_idx_2), .sweep_s(sweep_s_2), .done(done_2),
        .minterm_count(minterm_count_2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the table the function should hold and the last count.
    logic [15:0] m_table;
    int          m_count;

    typedef struct {
        logic [3:0] v;
        logic       e;
    } vec_t;
    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int popcount16(input logic [15:0] t);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(t[i]);
        return c;
    endfunction

    // Sweep on the N=4 instance. inj_kind 1: load 0 + start pulse at inj_idx;
    // inj_kind 2: reset at inj_idx.
    task automatic run_sweep(input logic do_load, input logic [15:0] tt,
                             input int inj_idx, input int inj_kind);
        int exp_cnt;
        int busy_cycles = 0;
        if (do_load) m_table = tt;
        exp_cnt = popcount16(m_table);
        load = do_load; tt_in = tt; start = 1'b1;
        tick();
        load = 1'b0; start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("sweep_busy", int'(busy), 1);
            check("sweep_valid", int'(sweep_valid), 1);
            check("sweep_idx", int'(sweep_idx), k);
            check("sweep_s", int'(sweep_s), int'(m_table[k]));
            check("sweep_done_low", int'(done), 0);
            busy_cycles++;
            if (k == inj_idx && inj_kind == 1) begin
                load = 1'b1; tt_in = 16'h0000; start = 1'b1;
            end
            if (k == inj_idx && inj_kind == 2) rst = 1'b1;
            tick();
            load = 1'b0; start = 1'b0;
            if (k == inj_idx && inj_kind == 2) begin
                rst = 1'b0;
                m_table = '0;
                m_count = 0;
                check("abort_busy", int'(busy), 0);
                check("abort_valid", int'(sweep_valid), 0);
                check("abort_done", int'(done), 0);
                check("abort_count", int'(minterm_count), 0);
                for (int j = 0; j < 20; j++) begin
                    check("abort_no_done", int'(done), 0);
                    tick();
                end
                return;
            end
        end
        check("busy_cycles", busy_cycles, 16);
        check("end_done", int'(done), 1);
        check("end_busy", int'(busy), 0);
        check("end_valid", int'(sweep_valid), 0);
        check("end_count", int'(minterm_count), exp_cnt);
        m_count = exp_cnt;
        tick();
        check("post_done", int'(done), 0);
        check("post_count", int'(minterm_count), m_count);
        check("post_idx_hold", int'(sweep_idx), 15);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; tt_in = '0; in_vec = '0;
        rst_2 = 1'b1; load_2 = 1'b0; start_2 = 1'b0; tt_in_2 = '0; in_vec_2 = '0;
        m_table = '0; m_count = 0;

        // Scenario 1: reset and idle
        tick(); tick();
        rst = 1'b0; rst_2 = 1'b0;
        check("rst_s", int'(s), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(sweep_valid), 0);
        check("rst_idx", int'(sweep_idx), 0);
        check("rst_sweep_s", int'(sweep_s), 0);
        check("rst_done", int'(done), 0);
        check("rst_count", int'(minterm_count), 0);
        for (int v = 0; v < 16; v++) begin
            in_vec = 4'(v);
            tick();
            check("rst_eval", int'(s), 0);
        end

        // Scenario 2: table-driven direct evaluation of 16'hAC3C
        vecs[0]  = '{4'd0,  1'b0}; vecs[1]  = '{4'd1,  1'b0};
        vecs[2]  = '{4'd2,  1'b1}; vecs[3]  = '{4'd3,  1'b1};
        vecs[4]  = '{4'd4,  1'b1}; vecs[5]  = '{4'd5,  1'b1};
        vecs[6]  = '{4'd6,  1'b0}; vecs[7]  = '{4'd7,  1'b0};
        vecs[8]  = '{4'd8,  1'b0}; vecs[9]  = '{4'd9,  1'b0};
        vecs[10] = '{4'd10, 1'b1}; vecs[11] = '{4'd11, 1'b1};
        vecs[12] = '{4'd12, 1'b0}; vecs[13] = '{4'd13, 1'b1};
        vecs[14] = '{4'd14, 1'b0}; vecs[15] = '{4'd15, 1'b1};
        load = 1'b1; tt_in = 16'hAC3C; m_table = 16'hAC3C;
        tick();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_vec = vecs[i].v;
            tick();
            check("eval_ac3c", int'(s), int'(vecs[i].e));
        end

        // Scenario 3: sweep of 16'hAC3C, count 8
        run_sweep(1'b0, 16'h0000, -1, 0);
        check("count_ac3c", int'(minterm_count), 8);

        // Load-edge ordering: s uses the old table on the load edge
        in_vec = 4'd2; load = 1'b1; tt_in = 16'h0000;
        tick();
        load = 1'b0;
        check("load_edge_old", int'(s), 1);
        tick();
        check("load_edge_new", int'(s), 0);
        m_table = 16'h0000;

        // Scenario 4: boundary tables
        run_sweep(1'b1, 16'h0000, -1, 0);
        check("count_zero", int'(minterm_count), 0);
        run_sweep(1'b1, 16'hFFFF, -1, 0);
        check("count_full", int'(minterm_count), 16);

        // Scenario 5: interference, then reset abort
        load = 1'b1; tt_in = 16'hAC3C;
        tick();
        load = 1'b0; m_table = 16'hAC3C;
        run_sweep(1'b0, 16'h0000, 5, 1);
        check("interf_count", int'(minterm_count), 8);
        in_vec = 4'd13;
        tick(); tick();
        check("interf_table_kept", int'(s), 1);
        run_sweep(1'b0, 16'h0000, 9, 2);
        check("abort_table_clear", int'(s), 0);

        // Scenario 6: simultaneous load+start
        run_sweep(1'b1, 16'h8001, -1, 0);
        check("count_8001", int'(minterm_count), 2);

        // N=2 sweep with simultaneous load+start
        load_2 = 1'b1; tt_in_2 = 4'b0110; start_2 = 1'b1;
        tick();
        load_2 = 1'b0; start_2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("n2_busy", int'(busy_2), 1);
            check("n2_idx", int'(sweep_idx_2), k);
            check("n2_sweep_s", int'(sweep_s_2), (k == 1 || k == 2) ? 1 : 0);
            tick();
        end
        check("n2_done", int'(done_2), 1);
        check("n2_busy_end", int'(busy_2), 0);
        check("n2_count", int'(minterm_count_2), 2);
        tick();
        check("n2_done_low", int'(done_2), 0);

        // Randomized tables against the reference model
        for (int it = 0; it < 12; it++) begin
            logic [15:0] rt;
            rt = 16'($urandom);
            load = 1'b1; tt_in = rt;
            tick();
            load = 1'b0; m_table = rt;
            for (int j = 0; j < 8; j++) begin
                logic [3:0] rv;
                rv = 4'($urandom_range(0, 15));
                in_vec = rv;
                tick();
                check("rand_eval", int'(s), int'(m_table[rv]));
            end
            run_sweep(1'b0, 16'h0000, -1, 0);
            check("rand_count", int'(minterm_count), popcount16(rt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sop_lut_sweeper.md
Name: sop_lut_sweeper

Overview:
- Parametrised, programmable successor to the fixed 4-input sum-of-products blocks.
- Stores an N-input truth table (2^N minterm bits) and evaluates it against a registered input vector.
- Has a hardware sweep engine that walks all 2^N input combinations, streams each result and counts minterms.
- Used as a self-checking boolean-function unit in exercise benches, replacing hand-written stimulus sequences.

Parameters:
N, 4, number of boolean inputs; truth table width is 2^N (N from 1 to 8).

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
load  input  1  write tt_in into truth table (IDLE only)
tt_in  input  2^N  truth table; bit i = f(input vector value i), MSB of vector = first variable (x)
in_vec  input  N  input vector for direct evaluation
s  output  1  registered f(in_vec)
start  input  1  begin sweep (IDLE only)
busy  output  1  sweep in progress
sweep_valid  output  1  sweep_idx/sweep_s valid this cycle
sweep_idx  output  N  input combination being reported
sweep_s  output  1  f(sweep_idx)
done  output  1  one-cycle pulse at sweep end
minterm_count  output  N+1  number of 1s in table from last completed sweep

Behaviour:
- One clock domain; reset is synchronous and active-high, taking effect on the clk edge where rst=1.
- Reset values: table=0, s=0, busy=0, sweep_valid=0, sweep_idx=0, sweep_s=0, done=0, minterm_count=0, state=IDLE.
- Direct eval: s <= table[in_vec] every cycle in every state; latency 1 cycle.
  - When load is accepted on the same edge, s uses the old table and reflects the new table one cycle later.
- Load: accepted only in IDLE; table <= tt_in on that edge. load in SWEEP/DONE is ignored, so the table is frozen while a sweep runs.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE: start=1 sampled at edge t -> SWEEP; internal idx=0, accumulator=0.
  - SWEEP: runs cycles t+1 .. t+2^N.
    - In each of those cycles: busy=1, sweep_valid=1, sweep_idx=k, sweep_s=table[k], for k=0..2^N-1 in increasing order.
    - Accumulator adds table[k] each cycle; width N+1 so a full table gives 2^N with no overflow.
    - After k=2^N-1 -> DONE.
  - DONE (cycle t+2^N+1): done=1 for exactly one cycle; busy=0, sweep_valid=0; minterm_count updated to final count. Then -> IDLE unconditionally.
- minterm_count holds its value until the next completed sweep. It is not cleared on start, only by rst.
- Outside SWEEP, sweep_idx and sweep_s hold their last values; consumers qualify them with sweep_valid.
- Simultaneous events:
  - start while busy or in DONE: ignored. No restart, no queuing.
  - load and start in the same IDLE cycle: the table is written and the sweep starts; the sweep uses the new table.
  - rst with any other input: rst wins. All registers take reset values and the table is cleared.
- Reset mid-sweep: aborts the sweep; no done pulse; minterm_count=0.
- idx wrap: the counter is N bits and terminates on the all-ones value, never wrapping to 0 inside SWEEP.
- N=1 edge case: sweep is 2 cycles, minterm_count width 2.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> all outputs 0; s=0 for all in_vec.
2. Load 16'hAC3C (minterms 2,3,4,5,10,11,13,15), drive in_vec 0..15 one per cycle -> s one cycle later follows 0,0,1,1,1,1,0,0,0,0,1,1,0,1,0,1.
3. Start the sweep on the 16'hAC3C table:
   - busy and sweep_valid high for exactly 16 cycles, sweep_idx 0..15 with sweep_s matching the pattern in scenario 2.
   - done pulses once on the 17th cycle after start; minterm_count=8.
4. Boundary tables: load 16'h0000 then sweep -> minterm_count=0; load 16'hFFFF then sweep -> minterm_count=16 (5'b10000, no overflow).
5. Sweep interference:
   - Mid-sweep (idx=5): pulse load with 16'h0000 and pulse start -> both ignored, count stays 8.
   - Then assert rst at idx=9 on a fresh sweep -> busy=0 next cycle, no done, minterm_count=0.
6. Same-cycle load+start with 16'h8001 -> sweep_s=1 only at idx 0 and 15, minterm_count=2. Repeat at N=2 with tt_in=4'b0110 -> 4-cycle sweep, minterm_count=2.
